// File: rtl/mu0_pkg.sv
// rtl/mu0_pkg.sv - MU0 control encodings and state enum (ST_STEP_WAIT exists only with MU0_STEP_EN)
package mu0_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    localparam logic [1:0] FS_PASS_B = 2'b00;
    localparam logic [1:0] FS_ADD    = 2'b01;
    localparam logic [1:0] FS_SUB    = 2'b10;
    localparam logic [1:0] FS_INC_B  = 2'b11;

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3
`ifdef MU0_STEP_EN
        ,
        ST_STEP_WAIT = 3'd4
`endif
    } state_t;

    // Opcodes whose EXEC phase waits on the memory handshake.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_STO) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/mu0_ctrl_decode.sv
// rtl/mu0_ctrl_decode.sv - combinational state/opcode to datapath strobe decode
module mu0_ctrl_decode
    import mu0_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] ir_op,
    input  logic       acc_n,
    input  logic       acc_z,
    input  logic       mem_rdy,
    output logic       a_sel,
    output logic       b_sel,
    output logic [1:0] alu_fs,
    output logic       acc_ce,
    output logic       pc_ce,
    output logic       ir_ce,
    output logic       pc_clr,
    output logic       acc_oe,
    output logic       mem_rq,
    output logic       mem_rnw,
    output logic       halted
);

    always_comb begin
        a_sel   = 1'b0;
        b_sel   = 1'b0;
        alu_fs  = FS_PASS_B;
        acc_ce  = 1'b0;
        pc_ce   = 1'b0;
        ir_ce   = 1'b0;
        pc_clr  = 1'b0;
        acc_oe  = 1'b0;
        mem_rq  = 1'b0;
        mem_rnw = 1'b0;
        halted  = 1'b0;

        case (state)
            ST_RST: begin
                pc_clr = 1'b1;
            end
            // Instruction read from PC while the ALU forms PC+1 on the address bus.
            ST_FETCH: begin
                mem_rq  = 1'b1;
                mem_rnw = 1'b1;
                b_sel   = 1'b1;
                alu_fs  = FS_INC_B;
                ir_ce   = mem_rdy;
                pc_ce   = mem_rdy;
            end
            ST_EXEC: begin
                case (ir_op)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        a_sel   = 1'b1;
                        mem_rq  = 1'b1;
                        mem_rnw = 1'b1;
                        acc_ce  = mem_rdy;
                        alu_fs  = (ir_op == OP_LDA) ? FS_PASS_B :
                                  (ir_op == OP_ADD) ? FS_ADD : FS_SUB;
                    end
                    OP_STO: begin
                        a_sel  = 1'b1;
                        mem_rq = 1'b1;
                        acc_oe = 1'b1;
                    end
                    // Jumps route IR[11:0] through the ALU into PC.
                    OP_JMP, OP_JGE, OP_JNE: begin
                        a_sel  = 1'b1;
                        b_sel  = 1'b1;
                        pc_ce  = (ir_op == OP_JMP) ? 1'b1 :
                                 (ir_op == OP_JGE) ? ~acc_n : ~acc_z;
                    end
                    default: begin
                    end
                endcase
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// rtl/mu0_control.sv - MU0 fetch/execute sequencer; MU0_STEP_EN adds single-step via step
module mu0_control
    import mu0_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ir_op,
    input  logic       acc_n,
    input  logic       acc_z,
    input  logic       mem_rdy,
`ifdef MU0_STEP_EN
    input  logic       step,
`endif
    output logic       a_sel,
    output logic       b_sel,
    output logic [1:0] alu_fs,
    output logic       acc_ce,
    output logic       pc_ce,
    output logic       ir_ce,
    output logic       pc_clr,
    output logic       acc_oe,
    output logic       mem_rq,
    output logic       mem_rnw,
    output logic       halted
);

`ifdef MU0_STEP_EN
    localparam state_t ST_NEXT_INSTR = ST_STEP_WAIT;
`else
    localparam state_t ST_NEXT_INSTR = ST_FETCH;
`endif

    state_t state;
    state_t next_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_RST:   next_state = ST_NEXT_INSTR;
            ST_FETCH: if (mem_rdy) next_state = ST_EXEC;
            ST_EXEC: begin
                if (ir_op == OP_STP) begin
                    next_state = ST_HALT;
                end else if (!is_mem_op(ir_op) || mem_rdy) begin
                    next_state = ST_NEXT_INSTR;
                end
            end
            ST_HALT:  next_state = ST_HALT;
`ifdef MU0_STEP_EN
            ST_STEP_WAIT: if (step) next_state = ST_FETCH;
`endif
            default:  next_state = ST_RST;
        endcase
    end

    mu0_ctrl_decode u_decode (
        .state   (state),
        .ir_op   (ir_op),
        .acc_n   (acc_n),
        .acc_z   (acc_z),
        .mem_rdy (mem_rdy),
        .a_sel   (a_sel),
        .b_sel   (b_sel),
        .alu_fs  (alu_fs),
        .acc_ce  (acc_ce),
        .pc_ce   (pc_ce),
        .ir_ce   (ir_ce),
        .pc_clr  (pc_clr),
        .acc_oe  (acc_oe),
        .mem_rq  (mem_rq),
        .mem_rnw (mem_rnw),
        .halted  (halted)
    );

endmodule
